br_order_buf: RTL and testbench

In-order branch order buffer in the fetch/retire path. It records every in-flight branch at dispatch and captures the resolved direction and target from execute. It retires branches oldest-first and drives the retire-time update stream (PC, direction, target, valid strobes) consumed by the branch target buffer's certain-write port. It also flags retire-time mispredictions.

---
 rtl/br_order_buf.sv | 152 +++++++++++++++
 tb/tb_br_order_buf.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/br_order_buf.sv
// In-order branch order buffer: records branches at dispatch, captures resolution,
// retires oldest-first into a registered BTB update stream. Optional BOB_MISPRED_EN adds mispredict detection.
module br_order_buf #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             alloc_vld_i,
    input  logic [63:0]      alloc_pc_i,
    input  logic [1:0]       alloc_typ_i,
    input  logic             alloc_pdir_i,
    input  logic [63:0]      alloc_ptar_i,
    output logic             alloc_rdy_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             res_vld_i,
    input  logic [TAG_W-1:0] res_tag_i,
    input  logic             res_dir_i,
    input  logic [63:0]      res_tar_i,
    input  logic             rt_en_i,
    output logic [TAG_W:0]   count_o,
    output logic             brcond_vld_rt_o,
    output logic             brindir_vld_rt_o,
    output logic             brdir_rt_o,
    output logic [63:0]      brtar_rt_o,
    output logic [63:0]      brpc_rt_o,
    output logic             mispred_rt_o
);

    localparam logic [1:0] TYP_COND  = 2'b00;
    localparam logic [1:0] TYP_INDIR = 2'b10;

    logic [TAG_W:0]   head_q, head_d, tail_q, tail_d, count;
    logic [DEPTH-1:0] vld_q, vld_d, rsv_q, rsv_d;
    logic [TAG_W-1:0] hidx, tidx;
    logic             do_alloc, do_res, do_ret;

    logic [63:0] pc_q  [DEPTH];
    logic [1:0]  typ_q [DEPTH];
    logic        dir_q [DEPTH];
    logic [63:0] tar_q [DEPTH];

    logic        ret_mis;

    assign count       = tail_q - head_q;
    assign count_o     = count;
    assign alloc_rdy_o = (count < (TAG_W+1)'(DEPTH));
    assign alloc_tag_o = tail_q[TAG_W-1:0];
    assign hidx        = head_q[TAG_W-1:0];
    assign tidx        = tail_q[TAG_W-1:0];

    // All decisions use registered state, so same-cycle alloc/resolve never enable a retire.
    assign do_alloc = alloc_vld_i && alloc_rdy_o && !flush_i;
    assign do_res   = res_vld_i && vld_q[res_tag_i] && !rsv_q[res_tag_i] && !flush_i;
    assign do_ret   = rt_en_i && vld_q[hidx] && rsv_q[hidx] && !flush_i;

    always_comb begin
        vld_d  = vld_q;
        rsv_d  = rsv_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush_i) begin
            vld_d  = '0;
            rsv_d  = '0;
            head_d = '0;
            tail_d = '0;
        end else begin
            if (do_ret) begin
                vld_d[hidx] = 1'b0;
                rsv_d[hidx] = 1'b0;
                head_d      = head_q + (TAG_W+1)'(1);
            end
            if (do_res) begin
                rsv_d[res_tag_i] = 1'b1;
            end
            if (do_alloc) begin
                vld_d[tidx] = 1'b1;
                rsv_d[tidx] = 1'b0;
                tail_d      = tail_q + (TAG_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            vld_q  <= '0;
            rsv_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            vld_q  <= vld_d;
            rsv_q  <= rsv_d;
        end
    end

    // Payload needs no reset: it is only read behind a valid+resolved entry.
    always_ff @(posedge clock) begin
        if (do_alloc) begin
            pc_q[tidx]  <= alloc_pc_i;
            typ_q[tidx] <= alloc_typ_i;
        end
        if (do_res) begin
            dir_q[res_tag_i] <= res_dir_i;
            tar_q[res_tag_i] <= res_tar_i;
        end
    end

`ifdef BOB_MISPRED_EN
    logic        pdir_q [DEPTH];
    logic [63:0] ptar_q [DEPTH];

    always_ff @(posedge clock) begin
        if (do_alloc) begin
            pdir_q[tidx] <= alloc_pdir_i;
            ptar_q[tidx] <= alloc_ptar_i;
        end
    end

    assign ret_mis = (dir_q[hidx] != pdir_q[hidx]) ||
                     (dir_q[hidx] && (tar_q[hidx] != ptar_q[hidx]));
`else
    logic unused_pred;
    assign unused_pred = ^{alloc_pdir_i, alloc_ptar_i};
    assign ret_mis     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            brcond_vld_rt_o  <= 1'b0;
            brindir_vld_rt_o <= 1'b0;
            brdir_rt_o       <= 1'b0;
            brtar_rt_o       <= '0;
            brpc_rt_o        <= '0;
            mispred_rt_o     <= 1'b0;
        end else if (do_ret) begin
            brcond_vld_rt_o  <= (typ_q[hidx] == TYP_COND);
            brindir_vld_rt_o <= (typ_q[hidx] == TYP_INDIR);
            brdir_rt_o       <= (typ_q[hidx] == TYP_INDIR) ? 1'b1 : dir_q[hidx];
            brtar_rt_o       <= tar_q[hidx];
            brpc_rt_o        <= pc_q[hidx];
            mispred_rt_o     <= ret_mis;
        end else begin
            brcond_vld_rt_o  <= 1'b0;
            brindir_vld_rt_o <= 1'b0;
            mispred_rt_o     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_br_order_buf.sv
// Directed bench for br_order_buf: vector table for the retire/flush flows,
// hand sequences for full-buffer wrap and asynchronous reset.
module tb_br_order_buf;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        alloc_vld_i = 1'b0;
    logic [63:0] alloc_pc_i = '0;
    logic [1:0]  alloc_typ_i = '0;
    logic        alloc_pdir_i = 1'b0;
    logic [63:0] alloc_ptar_i = '0;
    logic        alloc_rdy_o;
    logic [3:0]  alloc_tag_o;
    logic        res_vld_i = 1'b0;
    logic [3:0]  res_tag_i = '0;
    logic        res_dir_i = 1'b0;
    logic [63:0] res_tar_i = '0;
    logic        rt_en_i = 1'b0;
    logic [4:0]  count_o;
    logic        brcond_vld_rt_o, brindir_vld_rt_o, brdir_rt_o, mispred_rt_o;
    logic [63:0] brtar_rt_o, brpc_rt_o;

`ifdef BOB_MISPRED_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    always #5 clock = ~clock;

    br_order_buf #(.DEPTH(16), .TAG_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .flush_i(flush_i),
        .alloc_vld_i(alloc_vld_i), .alloc_pc_i(alloc_pc_i), .alloc_typ_i(alloc_typ_i),
        .alloc_pdir_i(alloc_pdir_i), .alloc_ptar_i(alloc_ptar_i),
        .alloc_rdy_o(alloc_rdy_o), .alloc_tag_o(alloc_tag_o),
        .res_vld_i(res_vld_i), .res_tag_i(res_tag_i), .res_dir_i(res_dir_i), .res_tar_i(res_tar_i),
        .rt_en_i(rt_en_i), .count_o(count_o),
        .brcond_vld_rt_o(brcond_vld_rt_o), .brindir_vld_rt_o(brindir_vld_rt_o),
        .brdir_rt_o(brdir_rt_o), .brtar_rt_o(brtar_rt_o), .brpc_rt_o(brpc_rt_o),
        .mispred_rt_o(mispred_rt_o)
    );

    typedef struct {
        logic        av;   logic [63:0] pc;  logic [1:0] typ; logic pd; logic [63:0] pt;
        logic        rv;   logic [3:0]  rtag; logic rd;       logic [63:0] rtar;
        logic        rt;   logic        fl;
        logic [4:0]  cnt;  logic rdy; logic [3:0] tag;
        logic        c;    logic ind; logic d; logic [63:0] epc; logic [63:0] etar; logic m;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_fail = 0;

    task automatic add(input logic av, input logic [63:0] pc, input logic [1:0] typ,
                       input logic pd, input logic [63:0] pt,
                       input logic rv, input logic [3:0] rtag, input logic rd, input logic [63:0] rtar,
                       input logic rt, input logic fl,
                       input logic [4:0] cnt, input logic rdy, input logic [3:0] tag,
                       input logic c, input logic ind, input logic d,
                       input logic [63:0] epc, input logic [63:0] etar, input logic m);
        vec_t v;
        v.av = av; v.pc = pc; v.typ = typ; v.pd = pd; v.pt = pt;
        v.rv = rv; v.rtag = rtag; v.rd = rd; v.rtar = rtar; v.rt = rt; v.fl = fl;
        v.cnt = cnt; v.rdy = rdy; v.tag = tag; v.c = c; v.ind = ind; v.d = d;
        v.epc = epc; v.etar = etar; v.m = m;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string p, input logic [4:0] cnt, input logic rdy,
                             input logic [3:0] tag, input logic c, input logic ind,
                             input logic d, input logic [63:0] pc, input logic [63:0] tar,
                             input logic m);
        chk({p, " count"},   64'(count_o),          64'(cnt));
        chk({p, " rdy"},     64'(alloc_rdy_o),      64'(rdy));
        chk({p, " tag"},     64'(alloc_tag_o),      64'(tag));
        chk({p, " cond"},    64'(brcond_vld_rt_o),  64'(c));
        chk({p, " indir"},   64'(brindir_vld_rt_o), 64'(ind));
        chk({p, " dir"},     64'(brdir_rt_o),       64'(d));
        chk({p, " pc"},      brpc_rt_o,             pc);
        chk({p, " tar"},     brtar_rt_o,            tar);
        chk({p, " mispred"}, 64'(mispred_rt_o),     64'(m));
    endtask

    task automatic idle();
        alloc_vld_i = 0; res_vld_i = 0; rt_en_i = 0; flush_i = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // av pc typ pd pt | rv tag d tar | rt fl || cnt rdy tag c ind d pc tar m
        add(1, 'h1000, 0, 1, 'h2000, 0, 0, 0, 0,       1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,           1, 0, 1, 'h2000,  1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0,           0, 0, 0, 0,       1, 0, 0, 1, 1, 1, 0, 1, 'h1000, 'h2000, 0);
        add(0, 0, 0, 0, 0,           0, 0, 0, 0,       1, 0, 0, 1, 1, 0, 0, 1, 'h1000, 'h2000, 0);
        add(1, 'hdead, 0, 0, 0,      0, 0, 0, 0,       1, 1, 0, 1, 0, 0, 0, 1, 'h1000, 'h2000, 0);
        // out-of-order resolve 2,0,1
        add(1, 'h100, 0, 0, 0,       0, 0, 0, 0,       1, 0, 1, 1, 1, 0, 0, 1, 'h1000, 'h2000, 0);
        add(1, 'h200, 1, 1, 'h240,   0, 0, 0, 0,       1, 0, 2, 1, 2, 0, 0, 1, 'h1000, 'h2000, 0);
        add(1, 'h300, 0, 1, 'h380,   0, 0, 0, 0,       1, 0, 3, 1, 3, 0, 0, 1, 'h1000, 'h2000, 0);
        add(0, 0, 0, 0, 0,           1, 2, 1, 'h380,   1, 0, 3, 1, 3, 0, 0, 1, 'h1000, 'h2000, 0);
        add(0, 0, 0, 0, 0,           0, 0, 0, 0,       1, 0, 3, 1, 3, 0, 0, 1, 'h1000, 'h2000, 0);
        add(0, 0, 0, 0, 0,           1, 0, 1, 'h140,   1, 0, 3, 1, 3, 0, 0, 1, 'h1000, 'h2000, 0);
        add(0, 0, 0, 0, 0,           1, 1, 1, 'h240,   1, 0, 2, 1, 3, 1, 0, 1, 'h100, 'h140, MIS);
        add(0, 0, 0, 0, 0,           0, 0, 0, 0,       1, 0, 1, 1, 3, 0, 0, 1, 'h200, 'h240, 0);
        add(0, 0, 0, 0, 0,           0, 0, 0, 0,       1, 0, 0, 1, 3, 1, 0, 1, 'h300, 'h380, 0);
        add(0, 0, 0, 0, 0,           0, 0, 0, 0,       0, 0, 0, 1, 3, 0, 0, 1, 'h300, 'h380, 0);
        // indirect, wrong target; held by rt_en_i low for a cycle
        add(1, 'h500, 2, 1, 'h3000,  0, 0, 0, 0,       0, 0, 1, 1, 4, 0, 0, 1, 'h300, 'h380, 0);
        add(0, 0, 0, 0, 0,           1, 3, 1, 'h3400,  0, 0, 1, 1, 4, 0, 0, 1, 'h300, 'h380, 0);
        add(0, 0, 0, 0, 0,           0, 0, 0, 0,       0, 0, 1, 1, 4, 0, 0, 1, 'h300, 'h380, 0);
        add(0, 0, 0, 0, 0,           0, 0, 0, 0,       1, 0, 0, 1, 4, 0, 1, 1, 'h500, 'h3400, MIS);
        // indirect resolved not-taken still reports dir=1
        add(1, 'h600, 2, 1, 'h700,   0, 0, 0, 0,       1, 0, 1, 1, 5, 0, 0, 1, 'h500, 'h3400, 0);
        add(0, 0, 0, 0, 0,           1, 4, 0, 'h604,   1, 0, 1, 1, 5, 0, 0, 1, 'h500, 'h3400, 0);
        add(0, 0, 0, 0, 0,           0, 0, 0, 0,       1, 0, 0, 1, 5, 0, 1, 1, 'h600, 'h604, MIS);
        add(0, 0, 0, 0, 0,           1, 7, 1, 'hdead,  1, 0, 0, 1, 5, 0, 0, 1, 'h600, 'h604, 0);
        // five outstanding, then flush with resolve/alloc/retire
        for (int i = 0; i < 5; i++)
            add(1, 64'('hA00 + i), 0, 0, 0, 0, 0, 0, 0, 1, 0,
                5'(i + 1), 1, 4'(6 + i), 0, 0, 1, 'h600, 'h604, 0);
        add(1, 'hbad, 0, 0, 0,       1, 5, 1, 'h1,     1, 1, 0, 1, 0, 0, 0, 1, 'h600, 'h604, 0);
        add(0, 0, 0, 0, 0,           1, 5, 1, 'h1,     1, 0, 0, 1, 0, 0, 0, 1, 'h600, 'h604, 0);
        add(0, 0, 0, 0, 0,           0, 0, 0, 0,       1, 0, 0, 1, 0, 0, 0, 1, 'h600, 'h604, 0);

        idle();
        reset_n = 0;
        repeat (2) @(posedge clock);
        #1;
        check_all("reset", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1;

        foreach (vq[k]) begin
            alloc_vld_i = vq[k].av; alloc_pc_i = vq[k].pc; alloc_typ_i = vq[k].typ;
            alloc_pdir_i = vq[k].pd; alloc_ptar_i = vq[k].pt;
            res_vld_i = vq[k].rv; res_tag_i = vq[k].rtag; res_dir_i = vq[k].rd; res_tar_i = vq[k].rtar;
            rt_en_i = vq[k].rt; flush_i = vq[k].fl;
            step();
            check_all($sformatf("vec%0d", k), vq[k].cnt, vq[k].rdy, vq[k].tag, vq[k].c,
                      vq[k].ind, vq[k].d, vq[k].epc, vq[k].etar, vq[k].m);
        end
        idle();

        // fill from empty (head=tail=0)
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill tag%0d", i), 64'(alloc_tag_o), 64'(i));
            alloc_vld_i = 1; alloc_pc_i = 64'(i); alloc_typ_i = 0;
            alloc_pdir_i = 0; alloc_ptar_i = 0;
            step();
        end
        idle();
        chk("full count", 64'(count_o), 16);
        chk("full rdy", 64'(alloc_rdy_o), 0);
        alloc_vld_i = 1; alloc_pc_i = 'h1700;
        step();
        idle();
        chk("alloc17 count", 64'(count_o), 16);
        chk("alloc17 tag", 64'(alloc_tag_o), 0);
        res_vld_i = 1; res_tag_i = 0; res_dir_i = 0; res_tar_i = 'h4;
        step();
        idle();
        chk("full res count", 64'(count_o), 16);
        chk("full res cond", 64'(brcond_vld_rt_o), 0);
        alloc_vld_i = 1; alloc_pc_i = 'hf00; rt_en_i = 1;
        step();
        check_all("full retire", 15, 1, 0, 1, 0, 0, 0, 'h4, 0);
        rt_en_i = 0;
        step();
        idle();
        chk("wrap alloc count", 64'(count_o), 16);
        chk("wrap alloc tag", 64'(alloc_tag_o), 1);
        chk("wrap alloc cond", 64'(brcond_vld_rt_o), 0);

        // asynchronous reset mid-cycle
        #3;
        reset_n = 0;
        #1;
        check_all("async reset", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1;
        step();
        res_vld_i = 1; res_tag_i = 0; res_dir_i = 1; res_tar_i = 'h9; rt_en_i = 1;
        step();
        res_vld_i = 0;
        step();
        idle();
        chk("post-reset count", 64'(count_o), 0);
        chk("post-reset cond", 64'(brcond_vld_rt_o), 0);
        chk("post-reset pc", brpc_rt_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
